// File: rtl/mips_pkg.sv
// Shared definitions for the instruction fetch path: default datapath width,
// the canonical NOP word and the fetch-queue FSM state type.
package mips_pkg;

  localparam int unsigned DATA_WIDTH = 32;
  localparam logic [31:0] INSTR_NOP  = 32'h0000_0000;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } ifq_state_t;

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO for the fetch queue. The head entry is held in its own
// register so the consumer sees a flop output, and it reads as all-zero
// whenever the FIFO is empty. Flush empties the FIFO and overrides push/pop.
module ifq_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] head,
  output logic [CntW-1:0]  count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d, remain;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_push, do_pop;

  assign count   = count_q;
  assign head    = head_q;
  assign empty   = (count_q == '0);
  assign full    = (count_q == CntW'(DEPTH));
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & (~full | do_pop) & ~flush;

  // Pointer, occupancy and next head-register value.
  always_comb begin
    wr_ptr_d = wr_ptr_q + PtrW'(do_push);
    rd_ptr_d = rd_ptr_q + PtrW'(do_pop);
    remain   = count_q - CntW'(do_pop);
    count_d  = remain + CntW'(do_push);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      head_d   = '0;
    end else if (remain == '0) begin
      // Nothing left behind the head: a same-cycle push bypasses storage.
      head_d = do_push ? push_data : '0;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: issues one word read at a time to instruction
// memory, queues {pc, instr} pairs in ifq_fifo and presents the head to the
// datapath. A redirect flushes the queue and swallows any response still owed.
// Optional build macro IFQ_STATS_EN adds saturating flush/starve counters.
module instr_fetch_queue #(
  parameter int unsigned          DATA_WIDTH = mips_pkg::DATA_WIDTH,
  parameter int unsigned          DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  redirect_valid,
  input  logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  mem_req_valid,
  output logic [DATA_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [DATA_WIDTH-1:0] instr_pc,
  input  logic                  instr_ready
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]           flush_count,
  output logic [15:0]           starve_count
`endif
);

  import mips_pkg::*;

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  ifq_state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0]     fetch_pc_q, fetch_pc_d;
  logic [CntW-1:0]           count;
  logic                      fifo_full, fifo_empty;
  logic [2*DATA_WIDTH-1:0]   head, push_entry;
  logic                      req_fire, push, pop;

  // One request in flight at most, so count < DEPTH reserves the slot.
  assign mem_req_valid = ~reset & (state_q == REQ) & (count < CntW'(DEPTH));
  assign mem_req_addr  = fetch_pc_q;
  assign req_fire      = mem_req_valid & mem_req_ready;

  assign push       = (state_q == WAIT) & mem_rsp_valid & ~redirect_valid;
  assign pop        = instr_valid & instr_ready & ~redirect_valid;
  // fetch_pc already advanced past the outstanding request.
  assign push_entry = {fetch_pc_q - DATA_WIDTH'(4), mem_rsp_data};

  assign instr_valid = ~fifo_empty;
  assign instr       = instr_valid ? head[DATA_WIDTH-1:0] : DATA_WIDTH'(INSTR_NOP);
  assign instr_pc    = instr_valid ? head[2*DATA_WIDTH-1:DATA_WIDTH] : '0;

  // Fetch FSM and fetch PC; redirect overrides the normal transition.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    unique case (state_q)
      REQ: begin
        if (req_fire) begin
          state_d    = WAIT;
          fetch_pc_d = fetch_pc_q + DATA_WIDTH'(4);
        end
      end
      WAIT:    if (mem_rsp_valid) state_d = REQ;
      DROP:    if (mem_rsp_valid) state_d = REQ;
      default: state_d = REQ;
    endcase
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[DATA_WIDTH-1:2], 2'b00};
      // Anything not back in REQ still has a response on its way; discard it.
      if (state_d != REQ) state_d = DROP;
    end
  end

  // FSM and fetch PC registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= REQ;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

  ifq_fifo #(
    .WIDTH (2 * DATA_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef IFQ_STATS_EN
  logic [15:0] flush_cnt_q, starve_cnt_q;

  assign flush_count  = flush_cnt_q;
  assign starve_count = starve_cnt_q;

  // Saturating event counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flush_cnt_q  <= '0;
      starve_cnt_q <= '0;
    end else begin
      if (redirect_valid && flush_cnt_q != '1) flush_cnt_q <= flush_cnt_q + 16'd1;
      if (instr_ready && !instr_valid && starve_cnt_q != '1) begin
        starve_cnt_q <= starve_cnt_q + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue. A small memory model answers each
// accepted request after mem_lat cycles with data = 32'h2008_0005 + address.
// Inputs change and outputs are sampled just after the falling clock edge.
module tb_instr_fetch_queue;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b1;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;
`ifdef IFQ_STATS_EN
  logic [15:0] flush_count;
  logic [15:0] starve_count;
`endif

  int passed = 0;
  int total  = 0;

  int          mem_lat   = 1;
  logic        pend      = 1'b0;
  int          pend_wait = 0;
  logic [31:0] pend_addr = '0;
  int          acc_count = 0;
  logic [31:0] acc_addr[$];

  instr_fetch_queue dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
`ifdef IFQ_STATS_EN
    ,
    .flush_count    (flush_count),
    .starve_count   (starve_count)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h2008_0005 + a;
  endfunction

  // One clock cycle, including the memory model's response for this cycle.
  task automatic tick();
    logic        acc;
    logic [31:0] a;
    acc = mem_req_valid & mem_req_ready;
    a   = mem_req_addr;
    @(posedge clk);
    @(negedge clk);
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = '0;
    if (reset) begin
      pend = 1'b0;
    end else begin
      if (acc) begin
        pend      = 1'b1;
        pend_wait = mem_lat;
        pend_addr = a;
        acc_count++;
        acc_addr.push_back(a);
      end
      if (pend) begin
        pend_wait--;
        if (pend_wait == 0) begin
          mem_rsp_valid = 1'b1;
          mem_rsp_data  = mem_word(pend_addr);
          pend          = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    reset          = 1'b1;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    mem_req_ready  = 1'b1;
    mem_lat        = 1;
    pend           = 1'b0;
    mem_rsp_valid  = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    acc_count = 0;
    acc_addr.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    total++; if (mem_req_valid !== 1'b0) $display("FAIL reset_req_valid: got %0b want 0", mem_req_valid); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL reset_instr_valid: got %0b want 0", instr_valid); else passed++;
    total++; if (instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", instr); else passed++;
    total++; if (instr_pc !== 32'h0) $display("FAIL reset_instr_pc: got %h want 0", instr_pc); else passed++;
    reset = 1'b0;
    #1;
    total++; if (mem_req_valid !== 1'b1) $display("FAIL release_req_valid: got %0b want 1", mem_req_valid); else passed++;
    total++; if (mem_req_addr !== 32'h0) $display("FAIL release_req_addr: got %h want 0", mem_req_addr); else passed++;
  endtask

  task automatic test_first_fetch();
    apply_reset();
    tick();
    total++; if (mem_req_valid !== 1'b0) $display("FAIL first_wait_req: got %0b want 0", mem_req_valid); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL first_not_yet: got %0b want 0", instr_valid); else passed++;
    tick();
    total++; if (instr_valid !== 1'b1) $display("FAIL first_valid: got %0b want 1", instr_valid); else passed++;
    total++; if (instr !== 32'h2008_0005) $display("FAIL first_instr: got %h want 20080005", instr); else passed++;
    total++; if (instr_pc !== 32'h0) $display("FAIL first_pc: got %h want 0", instr_pc); else passed++;
    total++; if (mem_req_addr !== 32'h4) $display("FAIL first_next_addr: got %h want 4", mem_req_addr); else passed++;
  endtask

  task automatic test_fill();
    apply_reset();
    repeat (20) tick();
    total++; if (acc_count != 4) $display("FAIL fill_req_count: got %0d want 4", acc_count); else passed++;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (acc_addr.size() <= i) $display("FAIL fill_addr%0d: got none want %h", i, 4 * i);
      else if (acc_addr[i] !== 32'(4 * i)) $display("FAIL fill_addr%0d: got %h want %h", i, acc_addr[i], 4 * i);
      else passed++;
    end
    total++; if (mem_req_valid !== 1'b0) $display("FAIL fill_full_hold: got %0b want 0", mem_req_valid); else passed++;
    total++; if (instr_pc !== 32'h0) $display("FAIL fill_head_pc: got %h want 0", instr_pc); else passed++;
  endtask

  // Runs from the full queue left by test_fill; includes a push+pop cycle.
  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * i) || instr !== mem_word(32'(4 * i)))
        $display("FAIL drain%0d: got v=%0b pc=%h instr=%h want v=1 pc=%h instr=%h",
                 i, instr_valid, instr_pc, instr, 4 * i, mem_word(32'(4 * i)));
      else passed++;
      instr_ready = 1'b1;
      tick();
    end
    instr_ready = 1'b0;
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    mem_lat = 3;
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    tick();
    redirect_valid = 1'b0;
    total++; if (mem_req_valid !== 1'b0) $display("FAIL rw_drop_req: got %0b want 0", mem_req_valid); else passed++;
    for (int n = 0; n < 8 && mem_req_valid !== 1'b1; n++) tick();
    total++; if (mem_req_valid !== 1'b1) $display("FAIL rw_timeout: got %0b want 1", mem_req_valid); else passed++;
    total++; if (mem_req_addr !== 32'h40) $display("FAIL rw_addr: got %h want 40", mem_req_addr); else passed++;
    total++; if (instr_valid !== 1'b0) $display("FAIL rw_dropped: got %0b want 0", instr_valid); else passed++;
    mem_lat = 1;
    tick();
    tick();
    total++; if (instr_pc !== 32'h40) $display("FAIL rw_first_pc: got %h want 40", instr_pc); else passed++;
    total++; if (instr !== 32'h2008_0045) $display("FAIL rw_first_instr: got %h want 20080045", instr); else passed++;
  endtask

  task automatic test_redirect_rsp();
    apply_reset();
    tick();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    instr_ready    = 1'b1;
    tick();
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    total++; if (instr_valid !== 1'b0) $display("FAIL rr_flushed: got %0b want 0", instr_valid); else passed++;
    total++; if (instr !== 32'h0) $display("FAIL rr_nop: got %h want 0", instr); else passed++;
    total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100)
      $display("FAIL rr_req: got v=%0b addr=%h want v=1 addr=100", mem_req_valid, mem_req_addr);
    else passed++;
    tick();
    tick();
    total++; if (instr_pc !== 32'h100 || instr !== 32'h2008_0105)
      $display("FAIL rr_head: got pc=%h instr=%h want pc=100 instr=20080105", instr_pc, instr);
    else passed++;
  endtask

  task automatic test_redirect_req();
    apply_reset();
    mem_req_ready = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0207;
    tick();
    redirect_valid = 1'b0;
    total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h204)
      $display("FAIL rq_new_addr: got v=%0b addr=%h want v=1 addr=204", mem_req_valid, mem_req_addr);
    else passed++;
    tick();
    total++; if (mem_req_addr !== 32'h204) $display("FAIL rq_stable: got %h want 204", mem_req_addr); else passed++;
    mem_req_ready  = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0300;
    tick();
    redirect_valid = 1'b0;
    total++; if (mem_req_valid !== 1'b0) $display("FAIL rq_drop_state: got %0b want 0", mem_req_valid); else passed++;
    tick();
    total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h300)
      $display("FAIL rq_refetch: got v=%0b addr=%h want v=1 addr=300", mem_req_valid, mem_req_addr);
    else passed++;
    tick();
    tick();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h300)
      $display("FAIL rq_head: got v=%0b pc=%h want v=1 pc=300", instr_valid, instr_pc);
    else passed++;
  endtask

  task automatic test_reset_mid();
    apply_reset();
    repeat (6) tick();
    total++; if (instr_valid !== 1'b1) $display("FAIL rm_queued: got %0b want 1", instr_valid); else passed++;
    reset = 1'b1;
    #1;
    total++; if (instr_valid !== 1'b0) $display("FAIL rm_async_valid: got %0b want 0", instr_valid); else passed++;
    total++; if (mem_req_valid !== 1'b0) $display("FAIL rm_async_req: got %0b want 0", mem_req_valid); else passed++;
    pend          = 1'b0;
    mem_rsp_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    total++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0)
      $display("FAIL rm_refetch: got v=%0b addr=%h want v=1 addr=0", mem_req_valid, mem_req_addr);
    else passed++;
    tick();
    tick();
    total++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0)
      $display("FAIL rm_head: got v=%0b pc=%h want v=1 pc=0", instr_valid, instr_pc);
    else passed++;
  endtask

`ifdef IFQ_STATS_EN
  task automatic test_stats();
    apply_reset();
    total++; if (flush_count !== 16'd0) $display("FAIL st_flush_reset: got %0d want 0", flush_count); else passed++;
    instr_ready = 1'b1;
    tick();
    tick();
    instr_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1000 + 32'(16 * i);
      tick();
      redirect_valid = 1'b0;
      tick();
    end
    total++; if (flush_count !== 16'd3) $display("FAIL st_flush: got %0d want 3", flush_count); else passed++;
    total++; if (starve_count !== 16'd2) $display("FAIL st_starve: got %0d want 2", starve_count); else passed++;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_fill();
    test_back_to_back();
    test_redirect_wait();
    test_redirect_rsp();
    test_redirect_req();
    test_reset_mid();
`ifdef IFQ_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
